// File: rtl/bitmap_tile_renderer.sv
// bitmap_tile_renderer: palette-mapped bitmap window with per-line row prefetch and 2-cycle pixel pipeline
// pix_clk/rstn: pixel clock, async active-low reset
// vs_in/hs_in/de_in/act_x/act_y: timing generator inputs
// row_req/row_addr/row_ack/row_data: one bitmap row fetched per video line
// underrun_clr/underrun: sticky flag for a line that started before its row arrived
// vs_out/hs_out/de_out/rgb_out: delay-matched syncs and registered colour
module bitmap_tile_renderer #(
  parameter int          X_BITS      = 12,
  parameter int          Y_BITS      = 12,
  parameter int          H_ACT       = 1280,
  parameter int          V_ACT       = 720,
  parameter int          COLS        = 16,
  parameter int          ROWS        = 32,
  parameter int          ROW_BITS    = 5,
  parameter int          BLOCK_SHIFT = 4,
  parameter int          GRID_EN     = 1,
  parameter logic [23:0] PAL0        = 24'hFFFFFF,
  parameter logic [23:0] PAL1        = 24'hFF0000,
  parameter logic [23:0] PAL2        = 24'h00FF00,
  parameter logic [23:0] PAL3        = 24'h000000,
  parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
  input  logic                pix_clk,
  input  logic                rstn,
  input  logic                vs_in,
  input  logic                hs_in,
  input  logic                de_in,
  input  logic [X_BITS-1:0]   act_x,
  input  logic [Y_BITS-1:0]   act_y,
  output logic                row_req,
  output logic [ROW_BITS-1:0] row_addr,
  input  logic                row_ack,
  input  logic [2*COLS-1:0]   row_data,
  input  logic                underrun_clr,
  output logic                vs_out,
  output logic                hs_out,
  output logic                de_out,
  output logic [23:0]         rgb_out,
  output logic                underrun
);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam logic [X_BITS-1:0] X_OFF = X_BITS'((H_ACT - (COLS << BLOCK_SHIFT)) / 2);
  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(H_ACT) - X_OFF;
  localparam logic [Y_BITS-1:0] Y_OFF = Y_BITS'((V_ACT - (ROWS << BLOCK_SHIFT)) / 2);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(V_ACT) - Y_OFF;
  localparam logic [X_BITS-1:0] XM = X_BITS'((1 << BLOCK_SHIFT) - 1);
  localparam logic [Y_BITS-1:0] YM = Y_BITS'((1 << BLOCK_SHIFT) - 1);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic vs1_q, hs1_q, de1_q, win1_q, grid1_q, vs2_q, hs2_q, de2_q;
  logic lv_q, lv_d, lok_q, ur_q, ur_d;
  logic [CW-1:0] col1_q, col1_d;
  logic [ROW_BITS-1:0] addr_q, addr_d;
  logic [Y_BITS-1:0] last_y_q, ty;
  logic [2*COLS-1:0] line_q, line_d;
  logic [23:0] rgb_q, rgb_d, pal;
  logic [COLS-1:0] lo, hi;
  logic [1:0] code;
  logic [X_BITS-1:0] xo;
  logic vs_rise, de_rise, de_fall, trig, ty_win, ack_ok, win, grid1_d;
  always_comb begin
    vs_rise = vs_in & ~vs1_q;
    de_rise = de_in & ~de1_q;
    de_fall = ~de_in & de1_q;
    // the frame's last line has no successor to prefetch
    trig = vs_rise | (de_fall & (last_y_q != Y_BITS'(V_ACT - 1)));
    ty = vs_rise ? '0 : last_y_q + Y_BITS'(1);
    ty_win = ty >= Y_OFF && ty < Y_MAX;
    ack_ok = state_q == REQ && row_ack;
    // a new trigger abandons any outstanding request
    state_d = trig ? (ty_win ? REQ : IDLE) : (ack_ok ? IDLE : state_q);
    addr_d = trig && ty_win ? ROW_BITS'((ty - Y_OFF) >> BLOCK_SHIFT) : addr_q;
    lv_d = trig ? ~ty_win : lv_q | ack_ok;
    line_d = !trig && ack_ok ? row_data : line_q;
    ur_d = (de_rise & ~lv_q) | (trig & state_q == REQ) | (ur_q & ~underrun_clr);
    win = act_x >= X_OFF && act_x < X_MAX && act_y >= Y_OFF && act_y < Y_MAX;
    xo = win ? act_x - X_OFF : '0;
    col1_d = CW'(xo >> BLOCK_SHIFT);
    grid1_d = GRID_EN != 0 && win && ((xo & XM) == '0 || ((act_y - Y_OFF) & YM) == '0);
    lo = line_q[COLS-1:0];
    hi = line_q[2*COLS-1:COLS];
    code = {hi[col1_q], lo[col1_q]};
    pal = code == 2'd0 ? PAL0 : code == 2'd1 ? PAL1 : code == 2'd2 ? PAL2 : PAL3;
    // lok_q freezes line validity at line start so a mid-line ack waits for the next line
    rgb_d = de1_q && win1_q && !grid1_q && lok_q ? pal : BORDER_RGB;
  end
  always_ff @(posedge pix_clk or negedge rstn)
    if (!rstn) begin
      vs1_q <= 1'b0;
      hs1_q <= 1'b0;
      de1_q <= 1'b0;
      win1_q <= 1'b0;
      grid1_q <= 1'b0;
      col1_q <= '0;
      vs2_q <= 1'b0;
      hs2_q <= 1'b0;
      de2_q <= 1'b0;
      rgb_q <= '0;
      state_q <= IDLE;
      addr_q <= '0;
      lv_q <= 1'b0;
      lok_q <= 1'b0;
      line_q <= '0;
      ur_q <= 1'b0;
      last_y_q <= '0;
    end else begin
      vs1_q <= vs_in;
      hs1_q <= hs_in;
      de1_q <= de_in;
      win1_q <= win;
      grid1_q <= grid1_d;
      col1_q <= col1_d;
      vs2_q <= vs1_q;
      hs2_q <= hs1_q;
      de2_q <= de1_q;
      rgb_q <= rgb_d;
      state_q <= state_d;
      addr_q <= addr_d;
      lv_q <= lv_d;
      lok_q <= de_rise ? lv_q : lok_q;
      line_q <= line_d;
      ur_q <= ur_d;
      last_y_q <= de_in ? act_y : last_y_q;
    end
  assign row_req = state_q == REQ;
  assign row_addr = addr_q;
  assign vs_out = vs2_q;
  assign hs_out = hs2_q;
  assign de_out = de2_q;
  assign rgb_out = rgb_q;
  assign underrun = ur_q;
endmodule
